// File: rtl/polyz_pack_ctrl_if.sv
// polyz_pack_ctrl_if
// Bundles the control handshake, the coefficient input stream and the packed
// word output stream of polyz_pack_ctrl.
//   start/busy/done  : run control from the signing FSM
//   in_coeff/in_valid/in_ready : signed 32-bit coefficient stream (valid/ready)
//   out_data/out_addr/out_valid/out_ready : 40-bit packed word + word index
//   err              : sticky coefficient range error
// Modports: master = the surrounding system, slave = the packer itself.
interface polyz_pack_ctrl_if #(
  parameter int L  = 4,
  parameter int N  = 256,
  parameter int AW = $clog2(L*N/2)
);
  logic          start;
  logic          busy;
  logic          done;
  logic [31:0]   in_coeff;
  logic          in_valid;
  logic          in_ready;
  logic [39:0]   out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;
  logic          err;

  modport master (
    output start, in_coeff, in_valid, out_ready,
    input  busy, done, in_ready, out_data, out_addr, out_valid, err
  );

  modport slave (
    input  start, in_coeff, in_valid, out_ready,
    output busy, done, in_ready, out_data, out_addr, out_valid, err
  );
endinterface

// File: rtl/polyz_pack_ctrl.sv
// polyz_pack_ctrl
// Streaming sequencer that packs the Dilithium signature vector z
// (L polynomials x N coefficients) into 20-bit-per-coefficient format.
// Coefficients arrive one per cycle, are paired, and each pair becomes one
// 40-bit word {b4,b3,b2,b1,b0} written at word index poly*(N/2)+pair.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : polyz_pack_ctrl_if.slave
//           start (in), busy/done (out)          run control
//           in_coeff/in_valid (in), in_ready (out) coefficient stream
//           out_data/out_addr/out_valid (out), out_ready (in) packed words
//           err (out)                            sticky range error
//
// Optional feature macro: POLYZ_RANGE_CHECK_EN
//   When defined, each accepted coefficient is checked against
//   -(2^19-1) <= a <= 2^19 and err latches on a violation until the next
//   accepted start. When undefined, err is tied to 0.
module polyz_pack_ctrl #(
  parameter int L  = 4,
  parameter int N  = 256,
  parameter int AW = $clog2(L*N/2)
) (
  input logic             clk,
  input logic             rst_n,
  polyz_pack_ctrl_if.slave bus
);

  localparam int          HALF   = N / 2;
  localparam int          PW     = (L > 1) ? $clog2(L) : 1;
  localparam int          QW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [31:0] OFFSET = 32'h0008_0000;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        state;
  logic          phase;
  logic [31:0]   a0;
  logic [PW-1:0] poly_cnt;
  logic [QW-1:0] pair_cnt;
  logic          busy_q;
  logic          done_q;
  logic          out_valid_q;
  logic [39:0]   out_data_q;
  logic [AW-1:0] out_addr_q;

  logic          in_ready_c;
  logic          accept;
  logic          pair_wrap;
  logic          poly_wrap;
  logic [31:0]   t0;
  logic [31:0]   t1;
  logic [39:0]   packed_word;
  logic [AW-1:0] word_addr;
  logic          unused_hi;

  // Phase 0 only fills the hold register, so it may proceed even while a
  // word is stuck at the output; phase 1 needs the output slot to be free
  // (or freeing this cycle).
  assign in_ready_c = (state == RUN) && (!phase || !out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;

  assign pair_wrap  = (pair_cnt == QW'(HALF - 1));
  assign poly_wrap  = (poly_cnt == PW'(L - 1));

  // t = 2^19 - a modulo 2^32; the format keeps only t[19:0].
  assign t0 = OFFSET - a0;
  assign t1 = OFFSET - bus.in_coeff;
  assign packed_word = {t1[19:12], t1[11:4], t1[3:0], t0[19:16], t0[15:8], t0[7:0]};
  assign unused_hi   = ^{t0[31:20], t1[31:20]};

  assign word_addr = AW'(int'(poly_cnt) * HALF + int'(pair_cnt));

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;

`ifdef POLYZ_RANGE_CHECK_EN
  logic err_q;
  logic out_of_range;

  assign out_of_range = ($signed(bus.in_coeff) < -32'sd524287) ||
                        ($signed(bus.in_coeff) >  32'sd524288);
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Run sequencer, pairing, counters and the single-entry output register.
  // The final word is the only one that can be pending in FLUSH, so its
  // handshake alone ends the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase       <= 1'b0;
      a0          <= '0;
      poly_cnt    <= '0;
      pair_cnt    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
`ifdef POLYZ_RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // Drained slot; a load in RUN below overrides this.
      if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            busy_q   <= 1'b1;
            phase    <= 1'b0;
            poly_cnt <= '0;
            pair_cnt <= '0;
`ifdef POLYZ_RANGE_CHECK_EN
            err_q    <= 1'b0;
`endif
          end
        end

        RUN: begin
          if (accept) begin
`ifdef POLYZ_RANGE_CHECK_EN
            if (out_of_range) begin
              err_q <= 1'b1;
            end
`endif
            if (!phase) begin
              a0    <= bus.in_coeff;
              phase <= 1'b1;
            end else begin
              out_data_q  <= packed_word;
              out_addr_q  <= word_addr;
              out_valid_q <= 1'b1;
              phase       <= 1'b0;
              if (pair_wrap) begin
                pair_cnt <= '0;
                poly_cnt <= poly_wrap ? '0 : poly_cnt + 1'b1;
                if (poly_wrap) begin
                  state <= FLUSH;
                end
              end else begin
                pair_cnt <= pair_cnt + 1'b1;
              end
            end
          end
        end

        FLUSH: begin
          if (out_valid_q && bus.out_ready) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
